cnt_sequencer: RTL

//  Controller that drives a WIDTH-bit up/down stepping counter (step 1/2, down select) to a commanded target.

---
 rtl/cnt_seq_pkg.sv | 21 ++
 rtl/cnt_seq_timer.sv | 24 ++
 rtl/cnt_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared types and default sizing for the counter sequencer.
package cnt_seq_pkg;

   localparam int WIDTH_DEF   = 4;
   localparam int DW_DEF      = 4;
   localparam int TIMEOUT_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STEP  = 3'd1,
      WAIT  = 3'd2,
      DWELL = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Larger of two widths; sizes the shared dwell/timeout timer.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cnt_seq_timer.sv
// Loadable down-counter shared by the dwell hold and the no-movement timeout.
module cnt_seq_timer #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] val,
   input  logic          tick,
   output logic          zero
);

   logic [TW-1:0] cnt;

   // Load wins over tick; tick saturates at zero.
   always_ff @(posedge clk) begin
      if (rst)                    cnt <= '0;
      else if (load)              cnt <= val;
      else if (tick && cnt != '0) cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/cnt_sequencer.sv
// Drives an up/down stepping counter to a commanded target, then dwells and
// reports done. The counter output is fed back on cnt_value.
module cnt_sequencer
   import cnt_seq_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic [DW-1:0]    cmd_dwell,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_en,
   output logic             cnt_down,
   output logic             cnt_step,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int TW = max2(DW, max2($clog2(TIMEOUT), 1));

   state_t           state, nstate;
   logic [WIDTH-1:0] tgt, snap;
   logic [DW-1:0]    dwell_q;
   logic             en_q;

   logic             acc, snap_ld, n_en, n_dn, n_st, n_err;
   logic             t_load, t_tick, t_zero;
   logic [TW-1:0]    t_val;

   // Direction and step size toward t from v; difference is one bit wider so
   // it never wraps, which keeps the counter from overshooting through 0/max.
   function automatic logic [1:0] plan(input logic [WIDTH-1:0] t,
                                       input logic [WIDTH-1:0] v);
      logic         dn;
      logic [WIDTH:0] d;
      dn = (t < v);
      d  = dn ? ({1'b0, v} - {1'b0, t}) : ({1'b0, t} - {1'b0, v});
      return {dn, (d >= (WIDTH+1)'(2))};
   endfunction

   cnt_seq_timer #(.TW(TW)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (t_load),
      .val  (t_val),
      .tick (t_tick),
      .zero (t_zero)
   );

   // Next state and next registered outputs. DWELL spends dwell+1 cycles
   // (the entry cycle plus dwell hold cycles); WAIT gives the counter
   // TIMEOUT cycles to move after each strobe.
   always_comb begin
      nstate  = state;
      acc     = 1'b0;
      snap_ld = 1'b0;
      n_en    = 1'b0;
      n_dn    = 1'b0;
      n_st    = 1'b0;
      n_err   = 1'b0;
      t_load  = 1'b0;
      t_tick  = 1'b0;
      t_val   = '0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               acc = 1'b1;
               if (cmd_target == cnt_value) begin
                  nstate = DWELL;
                  t_load = 1'b1;
                  t_val  = TW'(cmd_dwell);
               end else begin
                  nstate       = STEP;
                  n_en         = 1'b1;
                  {n_dn, n_st} = plan(cmd_target, cnt_value);
               end
            end
         end
         STEP: begin
            nstate  = WAIT;
            snap_ld = 1'b1;
            t_load  = 1'b1;
            t_val   = TW'(TIMEOUT - 1);
         end
         WAIT: begin
            if (cnt_value != snap) begin
               if (cnt_value == tgt) begin
                  nstate = DWELL;
                  t_load = 1'b1;
                  t_val  = TW'(dwell_q);
               end else begin
                  nstate       = STEP;
                  n_en         = 1'b1;
                  {n_dn, n_st} = plan(tgt, cnt_value);
               end
            end else if (t_zero) begin
               nstate = IDLE;
               n_err  = 1'b1;
            end else begin
               t_tick = 1'b1;
            end
         end
         DWELL: begin
            if (t_zero) nstate = DONE;
            else        t_tick = 1'b1;
         end
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
      if (abort && state != IDLE) begin
         nstate = IDLE;
         n_en   = 1'b0;
         n_dn   = 1'b0;
         n_st   = 1'b0;
         n_err  = 1'b0;
      end
   end

   // State, command latches and registered (Moore) outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tgt       <= '0;
         dwell_q   <= '0;
         snap      <= '0;
         en_q      <= 1'b0;
         cnt_down  <= 1'b0;
         cnt_step  <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= nstate;
         if (acc) begin
            tgt     <= cmd_target;
            dwell_q <= cmd_dwell;
         end
         if (snap_ld) snap <= cnt_value;
         en_q      <= n_en;
         cnt_down  <= n_dn;
         cnt_step  <= n_st;
         cmd_ready <= (nstate == IDLE);
         busy      <= (nstate == STEP) || (nstate == WAIT) || (nstate == DWELL);
         done      <= (nstate == DONE);
         err       <= n_err;
      end
   end

   // An abort landing on a strobe cycle must not advance the counter.
   assign cnt_en = en_q & ~abort;

endmodule
